// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit in EX: shift-add multiply, restoring divide.
// Latency: accept + 32 iterations, done_o 33 cycles after accept; x/0 and overflow done 1 cycle after accept.
// Backpressure: stall_o holds ID/EX while an op is accepted or iterating; drops in DONE and on flush_i.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   start_i, flush_i         valid M-op in EX; kill of the op in EX (priority over start_i)
//   funct3_i                 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   rs1_data_i, rs2_data_i   operands, latched on accept
//   stall_o                  combinational pipeline hold
//   done_o, result_o         one-cycle result strobe and registered result
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t state_q, state_d;

  logic [2:0]        op_q;     // latched funct3
  logic [XLEN-1:0]   opnd_q;   // multiplicand (mul) or divisor (div), magnitude
  logic [2*XLEN-1:0] acc_q;    // mul: {partial product hi, multiplier}; div: {remainder, dividend/quotient}
  logic              neg_q;    // final result needs negation
  logic [CW-1:0]     cnt_q;

  // ---------------------------------------------------------------
  // Operand decode on the raw inputs, only used at the accept edge
  // ---------------------------------------------------------------
  logic            in_is_div, in_a_signed, in_b_signed, in_a_neg, in_b_neg;
  logic [XLEN-1:0] in_a_mag, in_b_mag;
  logic            in_div_zero, in_div_ovf, in_fast, in_res_neg;
  logic [XLEN-1:0] in_fast_res;
  logic            accept;

  always_comb begin
    in_is_div   = funct3_i[2];
    // Divide: DIV/REM signed, DIVU/REMU unsigned.
    // Multiply: rs1 unsigned only for MULHU, rs2 unsigned for MULHSU and MULHU.
    in_a_signed = in_is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
    in_b_signed = in_is_div ? ~funct3_i[0] : ~funct3_i[1];
    in_a_neg    = in_a_signed & rs1_data_i[XLEN-1];
    in_b_neg    = in_b_signed & rs2_data_i[XLEN-1];
    // Negating INT_MIN yields INT_MIN, which is the correct unsigned magnitude.
    in_a_mag    = in_a_neg ? -rs1_data_i : rs1_data_i;
    in_b_mag    = in_b_neg ? -rs2_data_i : rs2_data_i;

    in_div_zero = in_is_div & (rs2_data_i == '0);
    in_div_ovf  = in_is_div & ~funct3_i[0] & (rs1_data_i == INT_MIN) & (rs2_data_i == '1);
    in_fast     = in_div_zero | in_div_ovf;

    // funct3_i[1] selects remainder among the divide ops.
    if (in_div_zero) in_fast_res = funct3_i[1] ? rs1_data_i : '1;
    else             in_fast_res = funct3_i[1] ? '0 : INT_MIN;

    // Remainder takes the dividend's sign; everything else the XOR of signs.
    in_res_neg  = (in_is_div & funct3_i[1]) ? in_a_neg : (in_a_neg ^ in_b_neg);
  end

  assign accept = (state_q == S_IDLE) & start_i & ~flush_i;

  // ---------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] acc_nxt;

  always_comb begin
    // Multiply: add multiplicand to the upper half when the multiplier LSB is set,
    // then shift the whole 64+1-bit quantity right by one.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    // The remainder stays below the divisor, so it always fits back in XLEN bits.
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
    div_ge   = ~div_diff[XLEN+1];
    rem_new  = div_ge ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    div_nxt  = {rem_new, acc_q[XLEN-2:0], div_ge};

    acc_nxt  = op_q[2] ? div_nxt : mul_nxt;
  end

  // ---------------------------------------------------------------
  // Sign fix-up of the value produced by the last iteration
  // ---------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_val;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    prod_fix = neg_q ? -acc_nxt : acc_nxt;
    div_val  = op_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    if (op_q[2])              final_res = neg_q ? -div_val : div_val;
    else if (op_q[1:0] == 2'b00) final_res = prod_fix[XLEN-1:0];
    else                      final_res = prod_fix[2*XLEN-1:XLEN];
  end

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = in_fast ? S_DONE : S_CALC;
        stall_o = start_i;
      end
      S_CALC: begin
        if (flush_i)                state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_DONE;
        stall_o = 1'b1;
      end
      S_DONE: begin
        // start_i is ignored here; a following op is taken in the next IDLE cycle.
        state_d = S_IDLE;
        done_o  = ~flush_i;
      end
      default: state_d = S_IDLE;
    endcase
    stall_o = stall_o & rst_ni & ~flush_i;
  end

  // ---------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_o <= '0;
    end else begin
      if (accept) begin
        op_q   <= funct3_i;
        neg_q  <= in_res_neg;
        cnt_q  <= '0;
        opnd_q <= in_is_div ? in_b_mag : in_a_mag;
        acc_q  <= {{XLEN{1'b0}}, (in_is_div ? in_a_mag : in_b_mag)};
        if (in_fast) result_o <= in_fast_res;
      end else if ((state_q == S_CALC) && !flush_i) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) result_o <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized and directed bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ex_muldiv #(.XLEN(32)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .flush_i    (flush_i),
    .funct3_i   (funct3_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .stall_o    (stall_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RISC-V M semantics computed directly with 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint     sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op as a single-cycle start pulse, scramble the inputs while it runs,
  // and check result, latency, stall cycles and done pulse width.
  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    logic [31:0] exp_res;
    int          exp_lat, cyc, lat, stalls;
    bit          got;
    logic [31:0] res;
    exp_res = ref_result(f, a, b);
    exp_lat = ref_fast(f, a, b) ? 1 : 33;
    got = 0; lat = -1; stalls = 0; res = '0; cyc = 0;
    @(posedge clk_i); #1;
    start_i = 1'b1; funct3_i = f; rs1_data_i = a; rs2_data_i = b;
    while (!got && cyc < 40) begin
      @(negedge clk_i);
      if (stall_o) stalls++;
      if (done_o) begin got = 1; lat = cyc; res = result_o; end
      @(posedge clk_i); #1;
      start_i    = 1'b0;
      funct3_i   = 3'($urandom_range(0, 7));
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
      cyc++;
    end
    check($sformatf("%s_done", tag), 64'(got), 64'd1);
    check($sformatf("%s_res", tag), 64'(res), 64'(exp_res));
    check($sformatf("%s_lat", tag), 64'(lat), 64'(exp_lat));
    check($sformatf("%s_stalls", tag), 64'(stalls), 64'(exp_lat));
    @(negedge clk_i);
    check($sformatf("%s_pulse", tag), 64'(done_o), 64'd0);
  endtask

  initial begin
    int dones, stalls, first_cyc, second_cyc;
    logic [31:0] r1, r2;
    logic [2:0]  f;

    rst_ni = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = '0; rs1_data_i = '0; rs2_data_i = '0;

    // Reset state, with start asserted so stall_o must still be gated by reset.
    repeat (2) @(posedge clk_i);
    #1 start_i = 1'b1;
    @(negedge clk_i);
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_result", 64'(result_o), 64'd0);
    start_i = 1'b0;
    rst_ni  = 1'b1;

    // Directed cases
    do_op("mul_neg",   3'd0, 32'd7, 32'hFFFF_FFFD);
    do_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000);
    do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'd2);
    do_op("div_neg",   3'd4, 32'hFFFF_FFF9, 32'd2);
    do_op("rem_neg",   3'd6, 32'hFFFF_FFF9, 32'd2);
    do_op("divu",      3'd5, 32'd100, 32'd7);
    do_op("remu",      3'd7, 32'd100, 32'd7);
    do_op("divu_zero", 3'd5, 32'd5, 32'd0);
    do_op("rem_zero",  3'd6, 32'd5, 32'd0);
    do_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Randomized cases
    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom_range(0, 7));
      do_op($sformatf("rnd%0d_f%0d", i, f), f, pick_operand(), pick_operand());
    end

    // Flush at cycle 10 of a DIV; result must keep the previous value (14).
    do_op("pre_flush", 3'd5, 32'd100, 32'd7);
    @(posedge clk_i); #1;
    start_i = 1'b1; funct3_i = 3'd4; rs1_data_i = 32'hFFFF_FC18; rs2_data_i = 32'd7;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (c == 5) check("flush_pre_stall", 64'(stall_o), 64'd1);
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flush_stall", 64'(stall_o), 64'd0);
    check("flush_done", 64'(done_o), 64'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    dones = 0; stalls = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (done_o) dones++;
      if (stall_o) stalls++;
    end
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_idle", 64'(stalls), 64'd0);
    check("flush_hold", 64'(result_o), 64'd14);
    do_op("post_flush", 3'd0, 32'd3, 32'd4);

    // Asynchronous reset in the middle of CALC.
    @(posedge clk_i); #1;
    start_i = 1'b1; funct3_i = 3'd0; rs1_data_i = 32'd9; rs2_data_i = 32'd9;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk_i);
    #2;
    check("arst_pre_stall", 64'(stall_o), 64'd1);
    #1 rst_ni = 1'b0;
    #1;
    check("arst_stall", 64'(stall_o), 64'd0);
    check("arst_done", 64'(done_o), 64'd0);
    check("arst_result", 64'(result_o), 64'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    check("arst_no_done", 64'(dones), 64'd0);
    rst_ni = 1'b1;
    do_op("post_rst", 3'd0, 32'd6, 32'd7);

    // Back-to-back MULs with start held across the DONE boundary.
    @(posedge clk_i); #1;
    start_i = 1'b1; funct3_i = 3'd0; rs1_data_i = 32'd2; rs2_data_i = 32'd3;
    dones = 0; first_cyc = -1; second_cyc = -1; r1 = '0; r2 = '0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk_i);
      if (done_o) begin
        dones++;
        if (dones == 1) begin first_cyc = c; r1 = result_o; end
        if (dones == 2) begin second_cyc = c; r2 = result_o; end
      end
      @(posedge clk_i); #1;
      if (dones == 1) begin rs1_data_i = 32'd4; rs2_data_i = 32'd5; end
      if (dones >= 2) start_i = 1'b0;
    end
    check("b2b_count", 64'(dones), 64'd2);
    check("b2b_res1", 64'(r1), 64'd6);
    check("b2b_res2", 64'(r2), 64'd20);
    check("b2b_first", 64'(first_cyc), 64'd33);
    check("b2b_gap", 64'(second_cyc - first_cyc), 64'd34);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- It consumes the registered rs1/rs2 operands and the decoded M-extension instruction.
- It holds the pipeline with a stall until the 32-bit result is ready. The EX result mux selects result_o on the cycle done_o is high.

Parameters:
XLEN, 32, operand/result width; only 32 is supported. The iteration counter is 5 bits (log2 XLEN).

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  EX holds a valid M-extension instruction
flush_i  in  1  kill the instruction in EX (mispredict/trap)
funct3_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1_data_i  in  32  operand A
rs2_data_i  in  32  operand B
stall_o  out  1  combinational; drives ID/EX and earlier enables low
done_o  out  1  result valid this cycle (1-cycle pulse)
result_o  out  32  result, valid when done_o=1

Behaviour:
- Reset: the asynchronous reset forces the following.
  - state=IDLE, counter=0, done_o=0, result_o=0, internal operand and accumulator registers=0.
  - stall_o=0 while rst_ni=0.
  - A reset in any state aborts the operation; no done_o is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_i=1 and flush_i=0 accepts the instruction. Operands and funct3 are latched; later changes on the inputs are ignored.
  - Divisor=0 or signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF) goes to DONE on the next cycle (fast path).
  - Otherwise the unit goes to CALC with counter=0.
- CALC: one iteration per cycle, 32 iterations (counter 0..31). At counter=31 the unit goes to DONE and writes the final sign-fixed value into result_o.
- Multiply:
  - Shift-add on operand magnitudes into a 64-bit product.
  - Sign rules: MUL/MULH treat both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned.
  - The product is negated if exactly one signed operand is negative.
  - MUL returns product[31:0]; the MULH variants return product[63:32].
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign(rs1) XOR sign(rs2), signed ops only.
  - Remainder sign = sign(rs1), signed ops only.
- Fast-path results:
  - x/0: quotient 0xFFFFFFFF (DIV and DIVU); remainder = rs1.
  - Overflow: quotient 0x80000000; remainder 0.
- DONE: done_o=1 for exactly one cycle, result_o valid, stall_o=0, so the pipeline advances at this edge. The next state is IDLE unconditionally; start_i in DONE is ignored.
- stall_o = rst_ni & ~flush_i & ((IDLE & start_i) | CALC).
- Latency, with accept at cycle 0:
  - Normal: done at cycle 33; stall_o high for cycles 0..32.
  - Fast path: done at cycle 1; stall_o high only in cycle 0.
- Back-to-back: a second M-instruction enters EX at the DONE edge and is accepted in the following IDLE cycle. There are no lost or duplicated operations.
- flush_i=1:
  - In IDLE: nothing is accepted.
  - In CALC/DONE: next state is IDLE, done_o is suppressed or not raised, and result_o holds its previous value.
  - flush_i has priority over start_i.
- result_o holds its last value outside DONE.
- No combinational path from the operand inputs to result_o.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3): stall_o=1 for 33 cycles; done_o at cycle 33 with result 0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 gives 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF gives 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 gives 0xFFFFFFFF.
- DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIVU 100/7 gives 14; REMU 100/7 gives 2; each done at cycle 33.
- Divide-by-zero and overflow fast path, each with done at cycle 1 and stall for 1 cycle:
  - DIVU 5/0 gives 0xFFFFFFFF; REM 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM gives 0.
- Flush and reset:
  - flush_i pulse at cycle 10 of a DIV: no done_o, stall_o drops in that cycle, state is IDLE; a following MUL 3x4 returns 12 at its cycle 33.
  - rst_ni low asynchronously mid-CALC: all outputs go to 0 immediately.
- Back-to-back MUL 2x3 then MUL 4x5, start_i held high across the boundary: exactly two done pulses, results 6 then 20, 34 cycles apart.
